// File: rtl/life_gen_ctrl.sv
// Generation controller for the life cell array: command decode, RUN divider, STEP, addressed writes, CLEAR sweep.
// Optional feature macro GEN_LIMIT_EN adds a gen_limit input that auto-stops RUN.
module life_gen_ctrl #(
   parameter int          ROWS         = 8,
   parameter int          COLS         = 8,
   parameter int          ROW_W        = 3,
   parameter int          COL_W        = 3,
   parameter int          DIV_W        = 24,
   parameter int unsigned RATE_DEFAULT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [ROW_W-1:0] cmd_row,
   input  logic [COL_W-1:0] cmd_col,
   input  logic             cmd_val,
   input  logic [DIV_W-1:0] cmd_rate,
`ifdef GEN_LIMIT_EN
   input  logic [15:0]      gen_limit,
`endif
   output logic             cell_enb,
   output logic             cell_write,
   output logic [ROW_W-1:0] cell_row,
   output logic [COL_W-1:0] cell_col,
   output logic             cell_val,
   output logic             running,
   output logic [15:0]      gen_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STEP  = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   localparam logic [2:0] OP_RUN  = 3'd1;
   localparam logic [2:0] OP_STOP = 3'd2;
   localparam logic [2:0] OP_STEP = 3'd3;
   localparam logic [2:0] OP_WR   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_SET  = 3'd6;

   localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
   localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS-1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);

   logic [1:0]       r_state;
   logic             r_ready, r_running, r_enb, r_write, r_val, r_pend;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic [15:0]      r_gen;
   logic [DIV_W-1:0] r_period, r_div;

   logic             w_acc, w_run, w_stop, w_step, w_wr, w_clr, w_set;
   logic             w_addr_ok, w_wr_go, w_tick, w_last, w_lim_hit;
   logic [DIV_W-1:0] w_per_nxt, w_div_nxt;

   assign w_acc  = cmd_valid & r_ready;
   assign w_run  = w_acc & (cmd_op == OP_RUN);
   assign w_stop = w_acc & (cmd_op == OP_STOP);
   assign w_step = w_acc & (cmd_op == OP_STEP);
   assign w_wr   = w_acc & (cmd_op == OP_WR);
   assign w_clr  = w_acc & (cmd_op == OP_CLR);
   assign w_set  = w_acc & (cmd_op == OP_SET);

   assign w_addr_ok = ({1'b0, cmd_row} < ROWS_L) && ({1'b0, cmd_col} < COLS_L);
   assign w_wr_go   = w_wr & w_addr_ok;
   assign w_per_nxt = w_set ? cmd_rate : r_period;
   // Divider free-wraps past a shrunken period; only an exact match resets it.
   assign w_div_nxt = (r_div == r_period) ? '0 : r_div + DIV_W'(1);
   assign w_tick    = (w_div_nxt == w_per_nxt);
   assign w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);

`ifdef GEN_LIMIT_EN
   assign w_lim_hit = (gen_limit != 16'd0) && r_enb && (r_gen == gen_limit);
`else
   assign w_lim_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_running <= 1'b0;
         r_enb     <= 1'b0;
         r_write   <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_val     <= 1'b0;
         r_gen     <= '0;
         r_period  <= DIV_W'(RATE_DEFAULT);
         r_div     <= '0;
         r_pend    <= 1'b0;
      end else begin
         r_enb    <= 1'b0;
         r_write  <= 1'b0;
         r_period <= w_per_nxt;
         if (r_state == S_CLEAR) begin
            if (w_last) begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_gen   <= '0;
            end else begin
               r_write <= 1'b1;
               if (r_col == COL_LAST) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
         end else if (w_clr) begin
            r_state   <= S_CLEAR;
            r_ready   <= 1'b0;
            r_running <= 1'b0;
            r_write   <= 1'b1;
            r_row     <= '0;
            r_col     <= '0;
            r_val     <= 1'b0;
            r_div     <= '0;
            r_pend    <= 1'b0;
         end else begin
            if (w_wr_go) begin
               r_write <= 1'b1;
               r_row   <= cmd_row;
               r_col   <= cmd_col;
               r_val   <= cmd_val;
            end
            if (r_state == S_RUN) begin
               if (w_stop || w_lim_hit) begin
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
                  r_div     <= '0;
                  r_pend    <= 1'b0;
               end else begin
                  r_div <= w_div_nxt;
                  // A write owns the shared lines; the tick waits one cycle in r_pend.
                  if (w_wr_go) begin
                     r_pend <= r_pend | w_tick;
                  end else begin
                     r_enb  <= r_pend | w_tick;
                     r_pend <= r_pend & w_tick;
                     if (r_pend | w_tick) r_gen <= r_gen + 16'd1;
                  end
               end
            end else begin
               r_state <= S_IDLE;
               r_div   <= '0;
               r_pend  <= 1'b0;
               if (w_run) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                  if (w_per_nxt == '0) begin
                     r_enb <= 1'b1;
                     r_gen <= r_gen + 16'd1;
                  end
               end else if (w_step) begin
                  r_state <= S_STEP;
                  r_enb   <= 1'b1;
                  r_gen   <= r_gen + 16'd1;
               end
            end
         end
      end
   end

   assign cmd_ready  = r_ready;
   assign cell_enb   = r_enb;
   assign cell_write = r_write;
   assign cell_row   = r_row;
   assign cell_col   = r_col;
   assign cell_val   = r_val;
   assign running    = r_running;
   assign gen_count  = r_gen;

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
Generation controller for the life cell array. Accepts commands over a valid/ready interface and drives the array's shared control lines:
- per-generation enable pulse (cell_enb)
- addressed cell writes (cell_write/cell_val with row/col decode done in the array)
- full-array clear sweep

It also runs the array free-running at a programmable rate or single-steps it, and counts generations. It sits between the host/UART command decoder and the cell array.

Parameters:
ROWS, 8, number of array rows
COLS, 8, number of array columns
ROW_W, 3, row address width (ceil log2 ROWS)
COL_W, 3, column address width (ceil log2 COLS)
DIV_W, 24, generation period register width
RATE_DEFAULT, 0, period value loaded at reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  3  0 NOP, 1 RUN, 2 STOP, 3 STEP, 4 WRITE, 5 CLEAR, 6 SET_RATE, 7 NOP
cmd_row  in  ROW_W  WRITE row
cmd_col  in  COL_W  WRITE column
cmd_val  in  1  WRITE value
cmd_rate  in  DIV_W  SET_RATE period P
cell_enb  out  1  one-cycle generation pulse to all cells
cell_write  out  1  write strobe to addressed cell
cell_row  out  ROW_W  write row address
cell_col  out  COL_W  write column address
cell_val  out  1  write data
running  out  1  high in RUN state
gen_count  out  16  generations issued since reset/CLEAR

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0 except cmd_ready=1; period=RATE_DEFAULT; divider=0.
- States:
  - IDLE: array halted.
  - RUN: free-running.
  - STEP: one pulse, then back to IDLE.
  - CLEAR: sweep.
- cmd_ready=1 in IDLE/RUN/STEP and 0 throughout CLEAR. All outputs registered.
- WRITE accepted cycle N:
  - cell_write=1 in cycle N+1 with cell_row/col/val = cmd fields.
  - Legal in IDLE and RUN.
  - Row >= ROWS or col >= COLS: command consumed, no strobe.
- RUN accepted cycle N:
  - Enter RUN at N+1 with divider=0.
  - Divider increments each cycle; when divider==P, cell_enb=1 for one cycle and divider returns to 0. Result: period P+1 cycles, first pulse at N+1+P.
  - P=0 gives a pulse every cycle.
  - RUN while already in RUN: no effect, divider not reset.
- STOP: RUN→IDLE next cycle; no further pulse; divider=0. STOP in IDLE is a no-op.
- STEP in IDLE: cell_enb=1 in cycle N+1, then IDLE. STEP in RUN is ignored.
- SET_RATE: period=cmd_rate from N+1. In RUN, the divider is not reset; if it already exceeds the new P, it continues to wrap at 2^DIV_W. Host must STOP first to re-time cleanly.
- CLEAR (any state):
  - Enter CLEAR and drop running.
  - Sweep row-major (row 0 col 0 … ROWS-1, COLS-1), one write per cycle, cell_val=0.
  - ROWS*COLS strobe cycles.
  - On the cycle after the last strobe: gen_count=0, state IDLE, cmd_ready=1.
- Collision: cell_enb and cell_write are never high in the same cycle. If a RUN tick coincides with a pending write, the write goes out first and the pulse is delayed one cycle. The divider is not re-aligned, so later pulses keep their original phase.
- gen_count increments on every cell_enb pulse; wraps 0xFFFF→0x0000.
- NOP/op 7: consumed, no effect.

Optional Feature:
GEN_LIMIT_EN
- Defined:
  - Adds input gen_limit[15:0].
  - In RUN, when a pulse makes gen_count == gen_limit, the controller auto-STOPs: IDLE on the next cycle, no further pulse.
  - gen_limit=0 disables the limit.
- Undefined: port absent; RUN continues until STOP/CLEAR.

Test Plan:
1. Reset mid-RUN with P=2 → outputs 0 immediately (async), cmd_ready=1; after release, no cell_enb until a new RUN.
2. SET_RATE 3 then RUN at cycle N → cell_enb pulses at N+4, N+8, N+12; gen_count 1,2,3; STOP → no further pulses.
3. WRITE (row 2, col 5, val 1) in IDLE → single cell_write cycle with cell_row=2, cell_col=5, cell_val=1. WRITE to row 9 with ROWS=8 → no strobe, cmd_ready stays 1.
4. CLEAR with ROWS=COLS=8 → exactly 64 consecutive strobes with val 0, addresses 0,0 to 7,7; cmd_ready low for 64 cycles; gen_count=0 after; running=0.
5. RUN P=0 with WRITE on the same tick → write cycle without enb, enb the following cycle, never both high together. STEP while running → ignored.
6. GEN_LIMIT_EN, gen_limit=5, RUN P=1 → exactly 5 pulses, then running=0 and gen_count=5.
